// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control and memory wait sequencing for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_rf_we,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_wR,
    input  logic             mem_rf_we,
    input  logic [4:0]       mem_wR,
    input  logic             wb_rf_we,
    input  logic [4:0]       wb_wR,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic          ex1, ex2, mem1, mem2, wb1, wb2;
    logic          load_use, mw, br, lu;

    function automatic logic hit(input logic we, input logic [4:0] wr, input logic [4:0] r, input logic used);
        return we && wr == r && r != 5'd0 && used;
    endfunction

    // Hazard detection, control decode and next-state; everything is held quiet while reset is high
    always_comb begin
        ex1 = hit(ex_rf_we, ex_wR, id_rs1, id_rs1_used);
        ex2 = hit(ex_rf_we, ex_wR, id_rs2, id_rs2_used);
        mem1 = hit(mem_rf_we, mem_wR, id_rs1, id_rs1_used);
        mem2 = hit(mem_rf_we, mem_wR, id_rs2, id_rs2_used);
        wb1 = hit(wb_rf_we, wb_wR, id_rs1, id_rs1_used);
        wb2 = hit(wb_rf_we, wb_wR, id_rs2, id_rs2_used);
        load_use = ex_is_load && (ex1 || ex2);
        mw = !rst && mem_req && !mem_ready;
        br = !rst && !mw && state_q != MEM_WAIT && ex_br_taken;
        lu = !rst && !mw && state_q == RUN && !ex_br_taken && load_use;
        pc_stall = mw || lu;
        if_id_stall = mw || lu;
        if_id_flush = br;
        id_ex_flush = br || lu;
        ex_mem_stall = mw;
        mem_wb_bubble = mw;
        fwd_rs1_sel = rst ? 2'b00 : (ex1 && !ex_is_load) ? 2'b01 : mem1 ? 2'b10 : wb1 ? 2'b11 : 2'b00;
        fwd_rs2_sel = rst ? 2'b00 : (ex2 && !ex_is_load) ? 2'b01 : mem2 ? 2'b10 : wb2 ? 2'b11 : 2'b00;
        state_d = mw ? MEM_WAIT : lu ? LD_STALL : RUN;
        wait_d = !mw ? '0 : state_q != MEM_WAIT ? WW'(1) : wait_q == WW'(WAIT_MAX) ? wait_q : wait_q + 1'b1;
        timeout_d = timeout_q || wait_d == WW'(WAIT_MAX);
    end

    // State, wait counter, sticky timeout and saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q <= '0;
            timeout_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
            timeout_q <= timeout_d;
            stall_q <= stall_q + CNT_W'(pc_stall && stall_q != '1);
            flush_q <= flush_q + CNT_W'(if_id_flush && flush_q != '1);
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed-vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_wR, mem_wR, wb_wR;
    logic id_rs1_used, id_rs2_used, ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we;
    logic ex_br_taken, mem_req, mem_ready;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_bubble;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;
    logic [5:0] ctl;
    int checks = 0;
    int failures = 0;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_BR   = 6'b001100;
    localparam logic [5:0] C_MW   = 6'b110011;

    pipe_hazard_ctrl #(.WAIT_MAX(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_wR(ex_wR),
        .mem_rf_we(mem_rf_we), .mem_wR(mem_wR), .wb_rf_we(wb_rf_we), .wb_wR(wb_wR),
        .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_bubble};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        {id_rs1, id_rs2, ex_wR, mem_wR, wb_wR} = '0;
        {id_rs1_used, id_rs2_used, ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we} = '0;
        {ex_br_taken, mem_req, mem_ready} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        clear();
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_wR = 5'd7;
        id_rs2 = 5'd7; id_rs2_used = 1'b1;
        mem_wR = 5'd7; mem_rf_we = 1'b1;
    endtask

    initial begin
        clear();
        ex_br_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        id_rs1 = 5'd5; id_rs1_used = 1'b1; ex_wR = 5'd5; ex_rf_we = 1'b1;
        step(); step();
        #1;
        chk("rst_ctl", 32'(ctl), 32'(C_NONE));
        chk("rst_fwd1", 32'(fwd_rs1_sel), 32'd0);
        chk("rst_stallcnt", 32'(stall_cnt), 32'd0);
        chk("rst_flushcnt", 32'(flush_cnt), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        clear();
        rst = 1'b0;
        step();
        #1;
        chk("run_idle_ctl", 32'(ctl), 32'(C_NONE));

        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        ex_wR = 5'd5; ex_rf_we = 1'b1; mem_wR = 5'd5; mem_rf_we = 1'b1;
        #1;
        chk("fwd_ex", 32'(fwd_rs1_sel), 32'd1);
        id_rs1 = 5'd0;
        #1;
        chk("fwd_x0", 32'(fwd_rs1_sel), 32'd0);
        id_rs1 = 5'd5; ex_rf_we = 1'b0;
        wb_wR = 5'd5; wb_rf_we = 1'b1;
        #1;
        chk("fwd_mem_over_wb", 32'(fwd_rs1_sel), 32'd2);
        mem_rf_we = 1'b0;
        #1;
        chk("fwd_wb", 32'(fwd_rs1_sel), 32'd3);
        id_rs1_used = 1'b0;
        #1;
        chk("fwd_unused", 32'(fwd_rs1_sel), 32'd0);

        set_load_use();
        #1;
        chk("lu_ctl", 32'(ctl), 32'(C_LU));
        chk("lu_fwd2", 32'(fwd_rs2_sel), 32'd2);
        step();
        #1;
        chk("ldstall_ctl", 32'(ctl), 32'(C_NONE));
        chk("ldstall_fwd2", 32'(fwd_rs2_sel), 32'd2);
        chk("lu_stallcnt", 32'(stall_cnt), 32'd1);
        step();
        clear();
        #1;
        chk("after_ld_idle", 32'(ctl), 32'(C_NONE));

        set_load_use();
        ex_br_taken = 1'b1;
        #1;
        chk("br_vs_lu_ctl", 32'(ctl), 32'(C_BR));
        step();
        clear();
        #1;
        chk("br_flushcnt", 32'(flush_cnt), 32'd1);
        chk("br_stallcnt", 32'(stall_cnt), 32'd1);

        mem_req = 1'b1; ex_br_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("memwait_ctl%0d", k), 32'(ctl), 32'(C_MW));
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("memready_ctl", 32'(ctl), 32'(C_NONE));
        step();
        #1;
        chk("post_ready_br", 32'(ctl), 32'(C_BR));
        chk("mw_stallcnt", 32'(stall_cnt), 32'd4);
        chk("mw_no_timeout", 32'(mem_timeout), 32'd0);
        step();
        clear();
        #1;
        chk("mw_flushcnt", 32'(flush_cnt), 32'd2);

        mem_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk($sformatf("to_cycle%0d", k), 32'(mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("to_ctl%0d", k), 32'(ctl), 32'(C_MW));
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("to_ready_ctl", 32'(ctl), 32'(C_NONE));
        step();
        clear();
        #1;
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        chk("to_stallcnt", 32'(stall_cnt), 32'd10);

        mem_req = 1'b1;
        step(); step();
        #1;
        chk("pre_rst_stallcnt", 32'(stall_cnt), 32'd12);
        chk("pre_rst_ctl", 32'(ctl), 32'(C_MW));
        #1;
        rst = 1'b1;
        #1;
        chk("midwait_rst_ctl", 32'(ctl), 32'(C_NONE));
        chk("midwait_rst_timeout", 32'(mem_timeout), 32'd0);
        chk("midwait_rst_stallcnt", 32'(stall_cnt), 32'd0);
        step();
        clear();
        rst = 1'b0;
        step();
        #1;
        chk("post_rst_ctl", 32'(ctl), 32'(C_NONE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
